// File: rtl/cpu_step_gen_pkg.sv
// Shared definitions for the CPU step generator: FSM encoding and the
// width of the issued-step counter.
package cpu_step_gen_pkg;

   localparam int STEP_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_STEP_IDLE = 2'd0,
      ST_STEP_HELD = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

endpackage

// File: rtl/cpu_step_gen_if.sv
// Board-side signal bundle of the step generator: raw button/switch in,
// advance pulse and status levels out.
interface cpu_step_gen_if;
   import cpu_step_gen_pkg::*;

   logic                  BTN_IN;
   logic                  RUN_SW;
   logic                  cpu_step;
   logic                  btn_level;
   logic                  run_mode;
   logic [STEP_CNT_W-1:0] step_count;

   // master drives the raw board inputs, slave is the generator itself
   modport master (
      output BTN_IN, RUN_SW,
      input  cpu_step, btn_level, run_mode, step_count
   );

   modport slave (
      input  BTN_IN, RUN_SW,
      output cpu_step, btn_level, run_mode, step_count
   );

endinterface

// File: rtl/cpu_step_gen_sync_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer: the level only
// changes after DEBOUNCE_CYCLES consecutive mismatching samples.
module sync_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int CNT_W           = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_level
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchronizer to one flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/cpu_step_gen.sv
// CPU advance-pulse generator: one pulse per debounced press in step mode,
// a RUN_DIV-periodic train in run mode. Macro CPU_STEP_COUNT_EN builds the step counter.
module cpu_step_gen
   import cpu_step_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int RUN_DIV         = 25000000,
   parameter int CNT_W           = 25
) (
   input  logic           Clock,
   input  logic           Reset,
   cpu_step_gen_if.slave  bus
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);

   logic             w_btn_level;
   logic             w_run_mode;
   logic             w_btn_rise;
   logic             w_step_next;
   state_t           r_state;
   state_t           w_state_next;
   logic             r_btn_prev;
   logic             r_cpu_step;
   logic [CNT_W-1:0] r_div;

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_btn_db (
      .clk     (Clock),
      .rst_n   (Reset),
      .i_raw   (bus.BTN_IN),
      .o_level (w_btn_level)
   );

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_run_db (
      .clk     (Clock),
      .rst_n   (Reset),
      .i_raw   (bus.RUN_SW),
      .o_level (w_run_mode)
   );

   // A held button carried out of run mode must not count as a fresh press.
   assign w_btn_rise = w_btn_level & ~r_btn_prev;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_STEP_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: default assignment first so every path assigns the target and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      if (w_run_mode) begin
         w_state_next = ST_RUN;
      end else begin
         unique case (r_state)
            ST_STEP_IDLE: if (w_btn_rise)   w_state_next = ST_STEP_HELD;
            ST_STEP_HELD: if (!w_btn_level) w_state_next = ST_STEP_IDLE;
            ST_RUN:                         w_state_next = ST_STEP_IDLE;
            default:                        w_state_next = ST_STEP_IDLE;
         endcase
      end
   end

   always_comb begin
      w_step_next = 1'b0;
      unique case (r_state)
         ST_STEP_IDLE: w_step_next = !w_run_mode && w_btn_rise;
         ST_RUN:       w_step_next = w_run_mode && (r_div == DIV_LAST);
         default:      w_step_next = 1'b0;
      endcase
   end

   // Divider only advances while staying in run mode; entry and exit both clear it.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_btn_prev <= 1'b0;
         r_cpu_step <= 1'b0;
         r_div      <= '0;
      end else begin
         r_btn_prev <= w_btn_level;
         r_cpu_step <= w_step_next;
         if (r_state == ST_RUN && w_state_next == ST_RUN) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + CNT_W'(1);
         end else begin
            r_div <= '0;
         end
      end
   end

`ifdef CPU_STEP_COUNT_EN
   logic [STEP_CNT_W-1:0] r_step_count;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_step_count <= '0;
      end else if (w_step_next) begin
         r_step_count <= r_step_count + STEP_CNT_W'(1);
      end
   end

   assign bus.step_count = r_step_count;
`else
   assign bus.step_count = '0;
`endif

   assign bus.cpu_step  = r_cpu_step;
   assign bus.btn_level = w_btn_level;
   assign bus.run_mode  = w_run_mode;

endmodule
